// File: rtl/controle_cofre.sv
// controle_cofre: safe controller holding the password, capturing attempts and tracking failures/lockout.
// Timed lockout is built only when CONTROLE_COFRE_BLOQUEIO_EN is defined.
module controle_cofre #(
  parameter int          MAX_TENTATIVAS  = 3,
  parameter int          BLOQUEIO_CICLOS = 1000,
  parameter logic [3:0]  SENHA_PADRAO    = 4'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] chaves,
  input  logic       btn_confirmar,
  input  logic       btn_programar,
  input  logic       aberto_in,
  input  logic       proximo_in,
  input  logic       errado_in,
  output logic [3:0] senha,
  output logic [3:0] tentativa,
  output logic       aberto,
  output logic       perto,
  output logic       bloqueado,
  output logic [1:0] erros
);
  typedef enum logic [1:0] {OCIOSO, AVALIA, ABERTO, BLOQUEADO} estado_t;
  localparam logic [1:0] MAX = 2'(MAX_TENTATIVAS);
  estado_t    est_q, est_d;
  logic [3:0] senha_q, senha_d, tent_q, tent_d;
  logic [1:0] erros_q, erros_d, inc;
  logic       perto_q, perto_d, aberto_q;
  logic [1:0] btn, hist_q, arm_q, press;
  logic       unused_errado;
  assign unused_errado = errado_in;
  assign btn   = {btn_programar, btn_confirmar};
  // arm_q blocks a button held across reset until it has been seen low
  assign press = btn & ~hist_q & arm_q;
  assign inc   = erros_q + 2'd1;
`ifdef CONTROLE_COFRE_BLOQUEIO_EN
  localparam int CW = $clog2(BLOQUEIO_CICLOS);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          bloq_q;
  assign bloqueado = bloq_q;
`else
  assign bloqueado = 1'b0;
`endif
  always_comb begin
    est_d   = est_q;
    senha_d = senha_q;
    tent_d  = tent_q;
    perto_d = perto_q;
    erros_d = erros_q;
`ifdef CONTROLE_COFRE_BLOQUEIO_EN
    cnt_d   = cnt_q;
`endif
    case (est_q)
      OCIOSO: if (press[0]) begin
        tent_d  = chaves;
        perto_d = 1'b0;
        est_d   = AVALIA;
      end
      AVALIA: if (aberto_in) begin
        est_d   = ABERTO;
        erros_d = 2'd0;
      end else begin
        perto_d = proximo_in;
`ifdef CONTROLE_COFRE_BLOQUEIO_EN
        erros_d = inc;
        est_d   = (inc == MAX) ? BLOQUEADO : OCIOSO;
        cnt_d   = (inc == MAX) ? CW'(BLOQUEIO_CICLOS - 1) : cnt_q;
`else
        erros_d = (erros_q >= MAX) ? erros_q : inc;
        est_d   = OCIOSO;
`endif
      end
      ABERTO: begin
        senha_d = press[1] ? chaves : senha_q;
        est_d   = (!press[1] && press[0]) ? OCIOSO : ABERTO;
      end
`ifdef CONTROLE_COFRE_BLOQUEIO_EN
      BLOQUEADO: if (cnt_q == '0) begin
        est_d   = OCIOSO;
        erros_d = 2'd0;
        perto_d = 1'b0;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
`endif
      default: est_d = OCIOSO;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      est_q    <= OCIOSO;
      senha_q  <= SENHA_PADRAO;
      tent_q   <= 4'd0;
      perto_q  <= 1'b0;
      erros_q  <= 2'd0;
      aberto_q <= 1'b0;
      hist_q   <= 2'b00;
      arm_q    <= 2'b00;
`ifdef CONTROLE_COFRE_BLOQUEIO_EN
      cnt_q    <= '0;
      bloq_q   <= 1'b0;
`endif
    end else begin
      est_q    <= est_d;
      senha_q  <= senha_d;
      tent_q   <= tent_d;
      perto_q  <= perto_d;
      erros_q  <= erros_d;
      aberto_q <= (est_d == ABERTO);
      hist_q   <= btn;
      arm_q    <= arm_q | ~btn;
`ifdef CONTROLE_COFRE_BLOQUEIO_EN
      cnt_q    <= cnt_d;
      bloq_q   <= (est_d == BLOQUEADO);
`endif
    end
  end
  assign senha     = senha_q;
  assign tentativa = tent_q;
  assign aberto    = aberto_q;
  assign perto     = perto_q;
  assign erros     = erros_q;
endmodule

// File: tb/tb_controle_cofre.sv
// tb_controle_cofre: directed bench for controle_cofre with a behavioural password checker in the loop.
// Lockout checks run when CONTROLE_COFRE_BLOQUEIO_EN is defined, saturation checks otherwise.
module tb_controle_cofre;
  logic       clk = 1'b0, rst = 1'b1;
  logic [3:0] chaves = 4'd0;
  logic       btn_confirmar = 1'b0, btn_programar = 1'b0;
  logic       aberto_in, proximo_in, errado_in;
  logic [3:0] senha, tentativa;
  logic       aberto, perto, bloqueado;
  logic [1:0] erros;
  int         n_chk = 0, n_pass = 0, d;

  controle_cofre #(.MAX_TENTATIVAS(3), .BLOQUEIO_CICLOS(8), .SENHA_PADRAO(4'd0)) dut (
    .clk(clk), .rst(rst), .chaves(chaves),
    .btn_confirmar(btn_confirmar), .btn_programar(btn_programar),
    .aberto_in(aberto_in), .proximo_in(proximo_in), .errado_in(errado_in),
    .senha(senha), .tentativa(tentativa), .aberto(aberto), .perto(perto),
    .bloqueado(bloqueado), .erros(erros)
  );

  always #5 clk = ~clk;

  always_comb begin
    d          = int'(tentativa) - int'(senha);
    aberto_in  = (d == 0);
    proximo_in = (d != 0) && (d >= -3) && (d <= 3);
    errado_in  = (d != 0);
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic c, input logic p);
    btn_confirmar = c;
    btn_programar = p;
    tick();
    btn_confirmar = 1'b0;
    btn_programar = 1'b0;
    tick();
  endtask

  task automatic tentar(input logic [3:0] v);
    chaves = v;
    press(1'b1, 1'b0);
  endtask

  initial begin
    repeat (2) tick();
    chk("rst_aberto", aberto, 0);
    chk("rst_erros", erros, 0);
    chk("rst_senha", senha, 0);
    chk("rst_tentativa", tentativa, 0);
    chk("rst_bloq", bloqueado, 0);
    rst = 1'b0;
    tick();
    tentar(4'd0);
    chk("open_aberto", aberto, 1);
    chk("open_erros", erros, 0);
    chaves = 4'd9;
    press(1'b0, 1'b1);
    chk("prog_senha", senha, 9);
    chk("prog_aberto", aberto, 1);
    press(1'b1, 1'b0);
    chk("close_aberto", aberto, 0);
    tentar(4'd7);
    chk("near_perto", perto, 1);
    chk("near_erros", erros, 1);
    chk("near_aberto", aberto, 0);
    tentar(4'd9);
    chk("ok_aberto", aberto, 1);
    chk("ok_erros", erros, 0);
    chk("ok_perto", perto, 0);
    chaves = 4'd5;
    press(1'b1, 1'b1);
    chk("simul_senha", senha, 5);
    chk("simul_aberto", aberto, 1);
    press(1'b1, 1'b0);
    chk("close2_aberto", aberto, 0);
    chaves = 4'd12;
    btn_confirmar = 1'b1;
    repeat (20) tick();
    btn_confirmar = 1'b0;
    tick();
    chk("held_erros", erros, 1);
    chk("held_perto", perto, 0);
    chk("held_tent", tentativa, 12);
`ifdef CONTROLE_COFRE_BLOQUEIO_EN
    tentar(4'd12);
    chk("lk_erros2", erros, 2);
    chk("lk_bloq_pre", bloqueado, 0);
    tentar(4'd12);
    chk("lk_bloq0", bloqueado, 1);
    chk("lk_erros3", erros, 3);
    chaves = 4'd5;
    for (int i = 1; i < 8; i++) begin
      btn_confirmar = i[0];
      tick();
      chk($sformatf("lk_bloq%0d", i), bloqueado, 1);
    end
    btn_confirmar = 1'b0;
    tick();
    chk("lk_end_bloq", bloqueado, 0);
    chk("lk_end_erros", erros, 0);
    chk("lk_end_aberto", aberto, 0);
    tick();
    chk("lk_ign_tent", tentativa, 12);
    chk("lk_ign_aberto", aberto, 0);
    repeat (3) tentar(4'd12);
    chk("lk2_bloq", bloqueado, 1);
    repeat (3) tick();
`else
    repeat (3) tentar(4'd12);
    chk("sat_erros", erros, 3);
    chk("sat_bloq", bloqueado, 0);
    chk("sat_aberto", aberto, 0);
`endif
    chaves = 4'd3;
    btn_confirmar = 1'b1;
    rst = 1'b1;
    #1;
    chk("arst_bloq", bloqueado, 0);
    chk("arst_erros", erros, 0);
    chk("arst_senha", senha, 0);
    chk("arst_tent", tentativa, 0);
    chk("arst_perto", perto, 0);
    tick();
    rst = 1'b0;
    repeat (2) tick();
    chk("hold_tent", tentativa, 0);
    chk("hold_erros", erros, 0);
    btn_confirmar = 1'b0;
    tick();
    tentar(4'd0);
    chk("post_aberto", aberto, 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
